// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the instruction encoder and decoder: op select
// encoding, type-0 word layout, opcode field constants and buffer depth.
package cpu_isa_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPC_W      = 9;
  localparam int ADDR_W     = 3;
  localparam int FIFO_DEPTH = 4;

  // Type-0 word layout: {type, opcode[8:0], addr1[2:0], addr2[2:0]}
  localparam int TYPE_BIT = 15;
  localparam int OPC_MSB  = 14;
  localparam int OPC_LSB  = 6;
  localparam int A1_MSB   = 5;
  localparam int A1_LSB   = 3;
  localparam int A2_MSB   = 2;
  localparam int A2_LSB   = 0;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SHOW = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  localparam logic [OPC_W-1:0] OPC_NOP  = 9'b000_000_000;
  localparam logic [OPC_W-1:0] OPC_ADD  = 9'b000_000_001;
  localparam logic [OPC_W-1:0] OPC_SHOW = 9'b000_010_010;

  typedef logic [INSTR_W-1:0] instr_t;

  function automatic logic [OPC_W-1:0] opcode_field(input op_e op);
    case (op)
      OP_ADD:  return OPC_ADD;
      OP_SHOW: return OPC_SHOW;
      default: return OPC_NOP;
    endcase
  endfunction

  function automatic instr_t encode_type0(input op_e op,
                                         input logic [ADDR_W-1:0] addr1,
                                         input logic [ADDR_W-1:0] addr2);
    instr_t w;
    w                  = '0;
    w[TYPE_BIT]        = 1'b0;
    w[OPC_MSB:OPC_LSB] = opcode_field(op);
    w[A1_MSB:A1_LSB]   = addr1;
    w[A2_MSB:A2_LSB]   = addr2;
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO with an explicit occupancy counter; output reads as
// zero while empty so unwritten storage never becomes visible.
module instr_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage is intentionally not reset; the empty mask below hides it.
  always_ff @(posedge clk) begin
    if (rst_n && w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: turns op/addr requests into type-0 words, buffers them
// for the issue stage, flags reserved ops and counts issued words.
import cpu_isa_pkg::*;

module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [2:0]  in_addr1,
  input  logic [2:0]  in_addr2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic        err,
  input  logic        err_clr,
  output logic [7:0]  issued_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid on either side.
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             w_in_accept;
  logic             w_rsvd;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  instr_t           w_enc_word;
  instr_t           w_head;
  logic             r_err;
  logic [7:0]       r_issued_cnt;

  assign w_rsvd      = (in_op == OP_RSVD);
  assign w_in_accept = in_valid && in_ready;
  assign w_push      = w_in_accept && !w_rsvd;
  assign w_pop       = out_valid && out_ready;
  assign w_enc_word  = encode_type0(op_e'(in_op), in_addr1, in_addr2);

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_enc_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_instr = w_head;

  // A new reserved-op acceptance wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_in_accept && w_rsvd) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_issued_cnt <= '0;
    end else if (w_pop) begin
      r_issued_cnt <= r_issued_cnt + 8'd1;
    end
  end

  assign err        = r_err;
  assign issued_cnt = r_issued_cnt;

  a_flags_match_count: assert property (@(posedge clk) disable iff (!rst_n)
    (in_ready == (w_count < CNT_W'(FIFO_DEPTH))) && (out_valid == (w_count != '0)));

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: drivers push hand-computed expected words
// into a queue; a negedge monitor pops and compares every issued word.
module tb_instr_encoder;

  localparam logic [1:0] T_NOP  = 2'b00;
  localparam logic [1:0] T_ADD  = 2'b01;
  localparam logic [1:0] T_SHOW = 2'b10;
  localparam logic [1:0] T_RSVD = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [2:0]  in_addr1 = 3'd0;
  logic [2:0]  in_addr2 = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic        err;
  logic        err_clr = 1'b0;
  logic [7:0]  issued_cnt;

  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_issued = 0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_instr = '0;

  instr_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_addr1   (in_addr1),
    .in_addr2   (in_addr2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .err        (err),
    .err_clr    (err_clr),
    .issued_cnt (issued_cnt)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_issued = 0;
      prev_hold  = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_instr", 32'(out_instr), 32'(prev_instr));
      end
      if (!out_valid) check("empty_instr_zero", 32'(out_instr), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", out_instr);
        end else begin
          check("issued_word", 32'(out_instr), 32'(exp_q.pop_front()));
        end
        exp_issued++;
      end
      prev_hold  = out_valid && !out_ready;
      prev_instr = out_instr;
    end
  end

  // Drivers
  task automatic send(input logic [1:0] op, input logic [2:0] a1, input logic [2:0] a2,
                      input logic [15:0] exp_word);
    int guard = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_addr1 = a1;
    in_addr2 = a2;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, guard);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (op != T_RSVD) exp_q.push_back(exp_word);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_drained"}, 32'(exp_q.size() == 0 && !out_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_instr", 32'(out_instr), 32'h0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_issued_cnt", 32'(issued_cnt), 32'd0);
    rst_n = 1'b1;

    // Basic encoding and 1-cycle latency
    out_ready = 1'b1;
    send(T_ADD, 3'd3, 3'd5, 16'h005D);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_instr", 32'(out_instr), 32'h005D);
    check("lat_issued_before", 32'(issued_cnt), 32'd0);
    wait_drain("basic");
    check("basic_issued_cnt", 32'(issued_cnt), 32'd1);

    // Order and backpressure
    out_ready = 1'b0;
    send(T_SHOW, 3'd2, 3'd0, 16'h0490);
    send(T_NOP, 3'd7, 3'd7, 16'h003F);
    repeat (3) @(posedge clk);
    #1;
    check("bp_head", 32'(out_instr), 32'h0490);
    check("bp_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_drain("order");
    check("order_issued_cnt", 32'(issued_cnt), 32'd3);

    // Full FIFO
    out_ready = 1'b0;
    send(T_ADD, 3'd0, 3'd1, 16'h0041);
    send(T_ADD, 3'd1, 3'd2, 16'h004A);
    send(T_ADD, 3'd2, 3'd3, 16'h0053);
    check("pre_full_ready", 32'(in_ready), 32'd1);
    send(T_ADD, 3'd4, 3'd5, 16'h0065);
    check("full_in_ready", 32'(in_ready), 32'd0);
    fork
      send(T_ADD, 3'd6, 3'd7, 16'h0077);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("fifth_waits", 32'(in_ready), 32'd0);
        check("full_head", 32'(out_instr), 32'h0041);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("pop_frees_slot", 32'(in_ready), 32'd1);
      end
    join
    check("refull_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait_drain("full");
    check("full_issued_cnt", 32'(issued_cnt), 32'd8);

    // Reserved op
    out_ready = 1'b0;
    check("err_idle", 32'(err), 32'd0);
    send(T_RSVD, 3'd1, 3'd1, 16'h0000);
    check("rsvd_err_set", 32'(err), 32'd1);
    check("rsvd_no_push", 32'(out_valid), 32'd0);
    check("rsvd_in_ready", 32'(in_ready), 32'd1);
    err_clr = 1'b1;
    send(T_RSVD, 3'd2, 3'd2, 16'h0000);
    check("set_beats_clr", 32'(err), 32'd1);
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("clr_alone", 32'(err), 32'd0);

    // Reset mid-operation with an in-flight handshake
    send(T_SHOW, 3'd1, 3'd1, 16'h0489);
    send(T_ADD, 3'd7, 3'd0, 16'h0078);
    send(T_NOP, 3'd2, 3'd5, 16'h0015);
    send(T_RSVD, 3'd0, 3'd0, 16'h0000);
    check("pre_rst_err", 32'(err), 32'd1);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_op     = T_ADD;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_issued_cnt", 32'(issued_cnt), 32'd0);
    check("mid_rst_out_instr", 32'(out_instr), 32'h0);
    check("mid_rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_no_push", 32'(out_valid), 32'd0);

    // Counter wrap over 256 issued words
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = ((i % 2) == 1) ? 16'h0480 : 16'h0040;
      w = w | 16'((i % 8) << 3) | 16'((i / 8) % 8);
      send(((i % 2) == 1) ? T_SHOW : T_ADD, 3'(i % 8), 3'((i / 8) % 8), w);
      if (i == 127) check("mid_wrap_no_backlog", 32'(in_ready), 32'd1);
    end
    wait_drain("wrap");
    check("wrap_issued_cnt", 32'(issued_cnt), 32'd0);
    check("wrap_word_count", 32'(exp_issued), 32'd256);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
